prescaled_mod_counter: RTL and testbench

PRESCALED_MOD_COUNTER -- requirements
Module: prescaled_mod_counter

---
 rtl/prescaled_mod_counter_if.sv | 23 ++
 rtl/prescaled_mod_counter.sv | 60 ++++++
 tb/tb_prescaled_mod_counter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prescaled_mod_counter_if.sv
// Control and status bundle for prescaled_mod_counter: enable/direction/load in,
// registered count plus step and terminal-count strobes out.
interface prescaled_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             tc;

  modport master (
    output en, up, load, load_val,
    input  count, tick, tc
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tick, tc
  );
endinterface

// File: rtl/prescaled_mod_counter.sv
// Up/down modulo-MODULUS counter that steps once every PRESCALE enabled cycles.
// tc is a same-cycle strobe so a PRESCALE=1 stage can cascade off it without a clock.
module prescaled_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  prescaled_mod_counter_if.slave bus
);

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic             pre_wrap;
  logic             at_term;
  logic             tick;

  // With PRESCALE=1 the prescaler never leaves 0, so pre_wrap is constantly true.
  assign pre_wrap = (pre_cnt == PRE_LAST);
  assign tick     = reset & bus.en & ~bus.load & pre_wrap;
  assign at_term  = bus.up ? (count_q == CNT_LAST) : (count_q == '0);

  assign bus.tick  = tick;
  assign bus.tc    = tick & at_term;
  assign bus.count = count_q;

  // Explicit wrap targets; at MODULUS = 2**WIDTH they coincide with natural overflow.
  always_comb begin
    step_val = count_q;
    if (bus.up) step_val = at_term ? '0 : count_q + CNT_ONE;
    else        step_val = at_term ? CNT_LAST : count_q - CNT_ONE;
  end

  assign load_clamped = (bus.load_val > CNT_LAST) ? CNT_LAST : bus.load_val;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let count see the updated pre_cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      count_q <= '0;
    end else if (bus.load) begin
      pre_cnt <= '0;
      count_q <= load_clamped;
    end else if (bus.en) begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + PRE_ONE;
      if (pre_wrap) count_q <= step_val;
    end
  end

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Randomized self-checking bench: five counter instances (default, prescaled, full-range,
// and a two-stage cascade) share stimulus and are checked against an arithmetic model.
module tb_prescaled_mod_counter;

  logic       clk;
  logic       reset;
  logic       en_s, up_s, load_s;
  logic [3:0] lv_s;

  int tests = 0;
  int fails = 0;

  // Instance order: 0 default, 1 prescale4/mod6, 2 prescale3/mod16, 3 chain low, 4 chain high.
  int   mod_m [5] = '{10, 6, 16, 10, 6};
  int   pre_p [5] = '{1, 4, 3, 1, 1};
  int   m_cnt [5];
  int   m_ph  [5];
  bit   m_en  [5];
  bit   exp_tick [5];
  bit   exp_tc   [5];
  logic [3:0] obs_count [5];
  logic       obs_tick  [5];
  logic       obs_tc    [5];
  logic [3:0] dut_count [5];
  logic       dut_tick  [5];
  logic       dut_tc    [5];

  prescaled_mod_counter_if #(.WIDTH(4)) if_def  ();
  prescaled_mod_counter_if #(.WIDTH(4)) if_p4   ();
  prescaled_mod_counter_if #(.WIDTH(4)) if_full ();
  prescaled_mod_counter_if #(.WIDTH(4)) if_lo   ();
  prescaled_mod_counter_if #(.WIDTH(4)) if_hi   ();

  prescaled_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_def  (.clk(clk), .reset(reset), .bus(if_def));
  prescaled_mod_counter #(.WIDTH(4), .MODULUS(6),  .PRESCALE(4)) u_p4   (.clk(clk), .reset(reset), .bus(if_p4));
  prescaled_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_full (.clk(clk), .reset(reset), .bus(if_full));
  prescaled_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_lo   (.clk(clk), .reset(reset), .bus(if_lo));
  prescaled_mod_counter #(.WIDTH(4), .MODULUS(6),  .PRESCALE(1)) u_hi   (.clk(clk), .reset(reset), .bus(if_hi));

  assign if_def.en  = en_s;  assign if_def.up  = up_s;  assign if_def.load  = load_s;  assign if_def.load_val  = lv_s;
  assign if_p4.en   = en_s;  assign if_p4.up   = up_s;  assign if_p4.load   = load_s;  assign if_p4.load_val   = lv_s;
  assign if_full.en = en_s;  assign if_full.up = up_s;  assign if_full.load = load_s;  assign if_full.load_val = lv_s;
  assign if_lo.en   = en_s;  assign if_lo.up   = up_s;  assign if_lo.load   = load_s;  assign if_lo.load_val   = lv_s;
  assign if_hi.en   = if_lo.tc;
  assign if_hi.up   = up_s;  assign if_hi.load   = load_s;  assign if_hi.load_val   = lv_s;

  assign dut_count[0] = if_def.count;  assign dut_tick[0] = if_def.tick;  assign dut_tc[0] = if_def.tc;
  assign dut_count[1] = if_p4.count;   assign dut_tick[1] = if_p4.tick;   assign dut_tc[1] = if_p4.tc;
  assign dut_count[2] = if_full.count; assign dut_tick[2] = if_full.tick; assign dut_tc[2] = if_full.tc;
  assign dut_count[3] = if_lo.count;   assign dut_tick[3] = if_lo.tick;   assign dut_tc[3] = if_lo.tc;
  assign dut_count[4] = if_hi.count;   assign dut_tick[4] = if_hi.tick;   assign dut_tc[4] = if_hi.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 5; i++) begin
      m_cnt[i] = 0;
      m_ph[i]  = 0;
      exp_tick[i] = 1'b0;
      exp_tc[i]   = 1'b0;
    end
  endtask

  // Drives one clock cycle, records expected strobes and DUT observations; no comparing here.
  task automatic apply(input bit e, input bit u, input bit l, input logic [3:0] lv);
    en_s = e; up_s = u; load_s = l; lv_s = lv;
    for (int i = 0; i < 5; i++) begin
      m_en[i]     = (i == 4) ? exp_tc[3] : e;
      exp_tick[i] = m_en[i] && !l && (m_ph[i] == pre_p[i] - 1);
      exp_tc[i]   = exp_tick[i] && (u ? (m_cnt[i] == mod_m[i] - 1) : (m_cnt[i] == 0));
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      obs_tick[i] = dut_tick[i];
      obs_tc[i]   = dut_tc[i];
    end
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      if (l) begin
        m_cnt[i] = (int'(lv) >= mod_m[i]) ? mod_m[i] - 1 : int'(lv);
        m_ph[i]  = 0;
      end else if (m_en[i]) begin
        if (exp_tick[i]) m_cnt[i] = u ? (m_cnt[i] + 1) % mod_m[i] : (m_cnt[i] + mod_m[i] - 1) % mod_m[i];
        m_ph[i] = (m_ph[i] + 1) % pre_p[i];
      end
    end
    #1;
    for (int i = 0; i < 5; i++) obs_count[i] = dut_count[i];
  endtask

  task automatic do_reset();
    en_s = 1'b0; up_s = 1'b1; load_s = 1'b0; lv_s = '0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) apply(1'b1, 1'b1, 1'b0, 4'd0);
    #2 reset = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (dut_count[i] !== 4'd0) begin fails++; $display("FAIL reset_count[%0d] got %0d expected 0", i, dut_count[i]); end
      tests++;
      if (dut_tick[i] !== 1'b0 || dut_tc[i] !== 1'b0) begin
        fails++; $display("FAIL reset_strobes[%0d] got tick=%b tc=%b expected 0/0", i, dut_tick[i], dut_tc[i]);
      end
    end
    en_s = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_count_up();
    int tc_hits = 0;
    int p4_first = -1;
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      apply(1'b1, 1'b1, 1'b0, 4'd0);
      if (obs_tc[0] === 1'b1) tc_hits++;
      if (p4_first < 0 && obs_count[1] === 4'd1) p4_first = c;
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (obs_count[i] !== 4'(m_cnt[i]) || obs_tick[i] !== exp_tick[i] || obs_tc[i] !== exp_tc[i]) begin
          fails++;
          $display("FAIL up[%0d] cyc %0d got cnt=%0d tick=%b tc=%b expected cnt=%0d tick=%b tc=%b",
                   i, c, obs_count[i], obs_tick[i], obs_tc[i], m_cnt[i], exp_tick[i], exp_tc[i]);
        end
      end
    end
    tests++;
    if (tc_hits != 2) begin fails++; $display("FAIL up_tc_hits got %0d expected 2", tc_hits); end
    tests++;
    if (obs_count[0] !== 4'd5) begin fails++; $display("FAIL up_final got %0d expected 5", obs_count[0]); end
    tests++;
    if (p4_first != 4) begin fails++; $display("FAIL p4_first_step got cycle %0d expected 4", p4_first); end
  endtask

  task automatic test_count_down();
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 4'd0);
    tests++;
    if (obs_count[0] !== 4'd9 || obs_tc[0] !== 1'b1) begin
      fails++; $display("FAIL down_first got cnt=%0d tc=%b expected cnt=9 tc=1", obs_count[0], obs_tc[0]);
    end
    for (int c = 0; c < 9; c++) begin
      apply(1'b1, 1'b0, 1'b0, 4'd0);
      tests++;
      if (obs_count[0] !== 4'(8 - c) || obs_tc[0] !== 1'b0) begin
        fails++; $display("FAIL down_run step %0d got cnt=%0d tc=%b expected cnt=%0d tc=0", c, obs_count[0], obs_tc[0], 8 - c);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    for (int c = 0; c < 3; c++) apply(1'b1, 1'b1, 1'b0, 4'd0);
    apply(1'b1, 1'b1, 1'b1, 4'd7);
    tests++;
    if (obs_tick[0] !== 1'b0 || obs_tc[0] !== 1'b0 || obs_tick[1] !== 1'b0) begin
      fails++; $display("FAIL load_strobes got tick=%b tc=%b p4tick=%b expected 0/0/0", obs_tick[0], obs_tc[0], obs_tick[1]);
    end
    tests++;
    if (obs_count[0] !== 4'd7 || obs_count[1] !== 4'd5 || obs_count[2] !== 4'd7) begin
      fails++; $display("FAIL load7 got %0d/%0d/%0d expected 7/5/7", obs_count[0], obs_count[1], obs_count[2]);
    end
    for (int c = 1; c <= 4; c++) begin
      apply(1'b1, 1'b1, 1'b0, 4'd0);
      tests++;
      if (obs_count[1] !== 4'(m_cnt[1]) || obs_tick[1] !== exp_tick[1]) begin
        fails++; $display("FAIL load_prescale cyc %0d got cnt=%0d tick=%b expected cnt=%0d tick=%b",
                          c, obs_count[1], obs_tick[1], m_cnt[1], exp_tick[1]);
      end
    end
    apply(1'b0, 1'b1, 1'b1, 4'd13);
    tests++;
    if (obs_count[0] !== 4'd9 || obs_count[1] !== 4'd5 || obs_count[2] !== 4'd13) begin
      fails++; $display("FAIL load13 got %0d/%0d/%0d expected 9/5/13", obs_count[0], obs_count[1], obs_count[2]);
    end
  endtask

  task automatic test_chain();
    int hi_max = 0;
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      apply(1'b1, 1'b1, 1'b0, 4'd0);
      if (int'(obs_count[4]) > hi_max) hi_max = int'(obs_count[4]);
      for (int i = 3; i < 5; i++) begin
        tests++;
        if (obs_count[i] !== 4'(m_cnt[i]) || obs_tc[i] !== exp_tc[i]) begin
          fails++; $display("FAIL chain[%0d] step %0d got cnt=%0d tc=%b expected cnt=%0d tc=%b",
                            i, c, obs_count[i], obs_tc[i], m_cnt[i], exp_tc[i]);
        end
      end
    end
    tests++;
    if (hi_max != 5 || obs_count[4] !== 4'd0) begin
      fails++; $display("FAIL chain_range got max=%0d final=%0d expected max=5 final=0", hi_max, obs_count[4]);
    end
  endtask

  task automatic test_async_reset_mid();
    do_reset();
    for (int c = 0; c < 6; c++) apply(1'b1, 1'b1, 1'b0, 4'd0);
    tests++;
    if (obs_count[0] !== 4'd6) begin fails++; $display("FAIL pre_reset got %0d expected 6", obs_count[0]); end
    #2 reset = 1'b0;
    #1;
    model_clear();
    tests++;
    if (dut_count[0] !== 4'd0 || dut_count[1] !== 4'd0 || dut_count[2] !== 4'd0) begin
      fails++; $display("FAIL async_reset got %0d/%0d/%0d expected 0/0/0", dut_count[0], dut_count[1], dut_count[2]);
    end
    en_s = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 8; c++) begin
      apply(1'b1, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (obs_count[i] !== 4'(m_cnt[i]) || obs_tick[i] !== exp_tick[i]) begin
          fails++; $display("FAIL restart[%0d] cyc %0d got cnt=%0d tick=%b expected cnt=%0d tick=%b",
                            i, c, obs_count[i], obs_tick[i], m_cnt[i], exp_tick[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit e, u, l;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      e = ($urandom_range(3) != 0);
      u = (c < 100) ? 1'b1 : $urandom_range(1);
      l = ($urandom_range(9) == 0);
      apply(e, u, l, 4'($urandom_range(15)));
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (obs_count[i] !== 4'(m_cnt[i]) || obs_tick[i] !== exp_tick[i] || obs_tc[i] !== exp_tc[i]) begin
          fails++;
          $display("FAIL rand[%0d] cyc %0d got cnt=%0d tick=%b tc=%b expected cnt=%0d tick=%b tc=%b",
                   i, c, obs_count[i], obs_tick[i], obs_tc[i], m_cnt[i], exp_tick[i], exp_tc[i]);
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    en_s   = 1'b0;
    up_s   = 1'b1;
    load_s = 1'b0;
    lv_s   = '0;
    model_clear();
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_chain();
    test_async_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
